ab_wire_pattern_gen: RTL and testbench

Stimulus generator that drives a synthetic A/B data-wire pair (READ_DATA+/READ_DATA-) for Phase 0 interface-detection self-test and loopback. It emits a programmed number of A-wire edges. The B wire runs in one of four modes: differential (inverted), single-ended (grounded), common-mode (in-phase) or static-high, with a programmable skew and optional periodic runt pulses. It lives in the 300 MHz HDD clock domain and its outputs feed the A/B correlation detector's pin inputs through a loopback mux.

---
 rtl/ab_wire_pattern_gen.sv | 196 +++++++++++++++++++
 tb/tb_ab_wire_pattern_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ab_wire_pattern_gen.sv
// Synthetic A/B read-data wire pair generator for interface-detection self-test
// and loopback: emits a programmed number of A edges with a skewed, mode-shaped B.
module ab_wire_pattern_gen #(
    parameter int RUNT_WIDTH = 3,
    parameter int SKEW_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [7:0]  half_period,
    input  logic [3:0]  skew,
    input  logic [15:0] edge_target,
    input  logic [7:0]  runt_every,
    output logic        wire_a,
    output logic        wire_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] edges_sent
);

    localparam logic [7:0] RUNT_RELOAD = 8'(RUNT_WIDTH);
    localparam logic [3:0] SKEW_MAX    = 4'(SKEW_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TAIL,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]  mode_q;
    logic [7:0]  period_q;
    logic [3:0]  skew_q;
    logic [15:0] target_q;
    logic [7:0]  runt_every_q;

    logic [7:0]  period_cnt;
    logic [7:0]  runt_cnt;
    logic [3:0]  tail_cnt;
    logic [SKEW_DEPTH-2:0] delay_line;

    logic        accept;
    logic        abort_now;
    logic        first_fire;
    logic        run_fire;
    logic        fire;
    logic        last_edge;
    logic        runt_hit;
    logic        a_next;
    logic        b_next;
    logic        tap;
    logic [7:0]  period_in;
    logic [3:0]  skew_in;
    logic [1:0]  mode_eff;
    logic [3:0]  skew_eff;
    logic [15:0] target_eff;
    logic [7:0]  runt_every_eff;
    logic [7:0]  period_eff;
    logic [15:0] edge_count_next;
    logic [7:0]  runt_count_next;
    logic [SKEW_DEPTH-1:0] taps;

    // On the accepting cycle the freshly presented config is used directly, so a
    // half-period of 1 can toggle A in the same cycle busy rises.
    always_comb begin
        accept         = (state == ST_IDLE) && start;
        abort_now      = (state != ST_IDLE) && abort;
        period_in      = (half_period == 8'd0) ? 8'd1 : half_period;
        skew_in        = (skew > SKEW_MAX) ? SKEW_MAX : skew;
        mode_eff       = accept ? mode        : mode_q;
        skew_eff       = accept ? skew_in     : skew_q;
        target_eff     = accept ? edge_target : target_q;
        runt_every_eff = accept ? runt_every  : runt_every_q;
        period_eff     = accept ? period_in   : period_q;

        edge_count_next = (accept ? 16'd0 : edges_sent) + 16'd1;
        runt_count_next = (accept ? 8'd0 : runt_cnt) + 8'd1;

        first_fire = accept && (edge_target != 16'd0) && (period_in == 8'd1);
        run_fire   = (state == ST_RUN) && (period_cnt == 8'd1) && !abort;
        fire       = first_fire || run_fire;
        last_edge  = fire && (edge_count_next == target_eff);
        runt_hit   = (runt_every_eff != 8'd0) && (runt_count_next == runt_every_eff);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if ((edge_target == 16'd0) || last_edge) begin
                        state_next = ST_TAIL;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (last_edge) begin
                    state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (tail_cnt == 4'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_now) begin
            state_next = ST_IDLE;
        end
    end

    // Tap 0 is the A value being registered this cycle, so skew 0 keeps B aligned.
    always_comb begin
        a_next = (state_next == ST_IDLE) ? 1'b0 : (wire_a ^ fire);
        taps   = {delay_line, a_next};
        tap    = taps[skew_eff];
        b_next = 1'b0;
        unique case (mode_eff)
            2'b00: b_next = ~tap;
            2'b01: b_next = 1'b0;
            2'b10: b_next = tap;
            2'b11: b_next = 1'b1;
            default: b_next = 1'b0;
        endcase
        if (state_next == ST_IDLE) begin
            b_next = ~(mode_eff[1] ^ mode_eff[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wire_a       <= 1'b0;
            wire_b       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            edges_sent   <= 16'd0;
            mode_q       <= 2'b00;
            period_q     <= 8'd1;
            skew_q       <= 4'd0;
            target_q     <= 16'd0;
            runt_every_q <= 8'd0;
            period_cnt   <= 8'd0;
            runt_cnt     <= 8'd0;
            tail_cnt     <= 4'd0;
            delay_line   <= '0;
        end else begin
            state      <= state_next;
            wire_a     <= a_next;
            wire_b     <= b_next;
            busy       <= (state_next == ST_RUN) || (state_next == ST_TAIL);
            done       <= (state_next == ST_DONE);
            delay_line <= (state_next == ST_IDLE) ? '0
                          : {delay_line[SKEW_DEPTH-3:0], a_next};

            if (accept) begin
                mode_q       <= mode;
                period_q     <= period_in;
                skew_q       <= skew_in;
                target_q     <= edge_target;
                runt_every_q <= runt_every;
                tail_cnt     <= skew_in;
                edges_sent   <= 16'd0;
                runt_cnt     <= 8'd0;
                period_cnt   <= period_in - 8'd1;
            end

            // The accept cycle already counts as the first countdown cycle.
            if (fire) begin
                edges_sent <= edge_count_next;
                runt_cnt   <= runt_hit ? 8'd0 : runt_count_next;
                period_cnt <= runt_hit ? RUNT_RELOAD : period_eff;
            end else if (state == ST_RUN) begin
                period_cnt <= period_cnt - 8'd1;
            end

            if ((state == ST_TAIL) && (tail_cnt != 4'd0)) begin
                tail_cnt <= tail_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ab_wire_pattern_gen.sv
// Scoreboard bench for ab_wire_pattern_gen: a waveform model predicts every
// output change per burst; a monitor pops and compares when the DUT changes.
module tb_ab_wire_pattern_gen;

    localparam int RUNT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  half_period;
    logic [3:0]  skew;
    logic [15:0] edge_target;
    logic [7:0]  runt_every;
    logic        wire_a;
    logic        wire_b;
    logic        busy;
    logic        done;
    logic [15:0] edges_sent;

    typedef struct {
        int          cyc;
        logic        a;
        logic        b;
        logic        bz;
        logic        d;
        logic [15:0] edges;
    } event_t;

    event_t     sbq[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       mon_en = 1'b0;
    logic [1:0] cur_mode = 2'b00;

    ab_wire_pattern_gen #(.RUNT_WIDTH(RUNT), .SKEW_DEPTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .mode(mode),
        .half_period(half_period),
        .skew(skew),
        .edge_target(edge_target),
        .runt_every(runt_every),
        .wire_a(wire_a),
        .wire_b(wire_b),
        .busy(busy),
        .done(done),
        .edges_sent(edges_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic idleB(input logic [1:0] m);
        return (m == 2'b00) || (m == 2'b11);
    endfunction

    function automatic int countLE(input int q[$], input int x);
        int c = 0;
        foreach (q[i]) if (q[i] <= x) c++;
        return c;
    endfunction

    // Waveform model: A edge k lands at P-1 + sum of preceding pulse widths; B is
    // A delayed by skew and shaped by mode; every level change becomes an event.
    task automatic buildModel(input logic [1:0] m, input int hp, input int sk,
                              input int n, input int re, input int s,
                              input int abortReq, output int xOut);
        int   et[$];
        int   p, t, doneRel, last, ed;
        logic a, b, bz, d, ad, pa, pb, pbz;
        event_t e;
        p = (hp == 0) ? 1 : hp;
        t = p - 1;
        for (int k = 1; k <= n; k++) begin
            et.push_back(t);
            t += (re != 0 && (k % re) == 0) ? RUNT : p;
        end
        doneRel = (n == 0) ? sk + 1 : et[n-1] + sk + 1;
        if (abortReq == -2) xOut = 1 + int'($urandom % doneRel);
        else xOut = abortReq;
        last = (xOut >= 0) ? xOut : doneRel + 1;
        pa = 1'b0; pb = idleB(cur_mode); pbz = 1'b0;
        for (int r = 0; r <= last; r++) begin
            if (r == last) begin
                a = 1'b0; b = idleB(m); bz = 1'b0; d = 1'b0;
                ed = (xOut >= 0) ? countLE(et, r - 1) : n;
            end else begin
                ed = countLE(et, r);
                a  = (ed % 2) == 1;
                ad = (countLE(et, r - sk) % 2) == 1;
                case (m)
                    2'b00: b = ~ad;
                    2'b01: b = 1'b0;
                    2'b10: b = ad;
                    default: b = 1'b1;
                endcase
                bz = (r < doneRel);
                d  = (r == doneRel);
            end
            if (a != pa || b != pb || bz != pbz || d) begin
                e.cyc = s + r; e.a = a; e.b = b; e.bz = bz; e.d = d; e.edges = 16'(ed);
                sbq.push_back(e);
            end
            pa = a; pb = b; pbz = bz;
        end
        cur_mode = m;
    endtask

    // Called just after a negedge; abortReq: -1 none, -2 random, >=1 relative cycle.
    task automatic applyStimulus(input logic [1:0] m, input int hp, input int sk,
                                 input int n, input int re, input int abortReq);
        int s, x;
        mode = m; half_period = 8'(hp); skew = 4'(sk);
        edge_target = 16'(n); runt_every = 8'(re);
        start = 1'b1; abort = 1'b0;
        s = cyc + 1;
        buildModel(m, hp, sk, n, re, s, abortReq, x);
        @(negedge clk);
        start = 1'b0;
        if (x >= 0) begin
            while (cyc < s + x - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic a, input logic b,
                               input logic bz, input logic d, input logic [15:0] ed);
        vectors++;
        if (wire_a !== a || wire_b !== b || busy !== bz || done !== d || edges_sent !== ed) begin
            miscompares++;
            $display("[TB] FAIL %s got a=%b b=%b busy=%b done=%b edges=%0d required a=%b b=%b busy=%b done=%b edges=%0d",
                     name, wire_a, wire_b, busy, done, edges_sent, a, b, bz, d, ed);
        end
    endtask

    task automatic waitDrain(input string name);
        int k = 0;
        while (sbq.size() != 0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_drain got %0d events pending after %0d cycles required 0 pending",
                     name, sbq.size(), k);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic runMonitor();
        logic   pa = 1'b0, pb = 1'b0, pbz = 1'b0;
        event_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (wire_a !== pa || wire_b !== pb || busy !== pbz || done === 1'b1)) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_change got cyc=%0d a=%b b=%b busy=%b done=%b edges=%0d required no change",
                             cyc, wire_a, wire_b, busy, done, edges_sent);
                end else begin
                    e = sbq.pop_front();
                    if (cyc != e.cyc || wire_a !== e.a || wire_b !== e.b || busy !== e.bz ||
                        done !== e.d || edges_sent !== e.edges) begin
                        miscompares++;
                        $display("[TB] FAIL event got cyc=%0d a=%b b=%b busy=%b done=%b edges=%0d required cyc=%0d a=%b b=%b busy=%b done=%b edges=%0d",
                                 cyc, wire_a, wire_b, busy, done, edges_sent,
                                 e.cyc, e.a, e.b, e.bz, e.d, e.edges);
                    end
                end
            end
            pa = wire_a; pb = wire_b; pbz = busy;
        end
    endtask

    task automatic doReset(input string name);
        @(posedge clk); #1 mon_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput(name, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        sbq.delete();
        cur_mode = 2'b00;
        @(negedge clk);
        checkOutput({name, "_idle"}, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        @(posedge clk); #1 mon_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
        half_period = 8'd0; skew = 4'd0; edge_target = 16'd0; runt_every = 8'd0;
        fork
            runMonitor();
        join_none
        doReset("power_on_reset");

        $display("[TB] differential, half_period 4, 64 edges");
        applyStimulus(2'b00, 4, 0, 64, 0, -1);
        waitDrain("diff64");

        $display("[TB] single-ended, half_period 6, 100 edges");
        applyStimulus(2'b01, 6, 5, 100, 0, -1);
        waitDrain("se100");

        $display("[TB] differential, skew 3, with ignored start mid-run");
        applyStimulus(2'b00, 10, 3, 12, 0, -1);
        repeat (30) @(negedge clk);
        start = 1'b1; mode = 2'b11; edge_target = 16'd2; half_period = 8'd1;
        @(negedge clk);
        start = 1'b0;
        waitDrain("skew3");

        $display("[TB] runt every 4 edges");
        applyStimulus(2'b00, 8, 2, 16, 4, -1);
        waitDrain("runt4");

        $display("[TB] abort at 10 edges then immediate restart");
        applyStimulus(2'b00, 4, 0, 64, 0, 41);
        applyStimulus(2'b10, 3, 4, 6, 0, -1);
        waitDrain("abort_restart");

        $display("[TB] zero edge target with ignored start during tail");
        applyStimulus(2'b00, 5, 5, 0, 0, -1);
        start = 1'b1; edge_target = 16'd7; skew = 4'd0;
        @(negedge clk);
        start = 1'b0;
        waitDrain("zero_target");

        $display("[TB] corner configs");
        applyStimulus(2'b11, 3, 2, 5, 0, -1);
        waitDrain("static_high");
        applyStimulus(2'b10, 0, 15, 5, 1, -1);
        waitDrain("hp0_skew15");
        applyStimulus(2'b00, 1, 0, 1, 0, -1);
        waitDrain("single_edge");

        $display("[TB] randomized bursts");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 15),
                          $urandom_range(0, 24), $urandom_range(0, 5),
                          ($urandom_range(0, 3) == 0) ? -2 : -1);
            waitDrain("random");
        end

        $display("[TB] reset mid-burst");
        applyStimulus(2'b10, 5, 2, 30, 0, -1);
        repeat (40) @(negedge clk);
        doReset("mid_burst_reset");
        applyStimulus(2'b00, 2, 1, 8, 3, -1);
        waitDrain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
